// File: rtl/instr_sequencer_if.sv
// Sequencer bus: instruction/flag inputs from the datapath and the
// control strobes back to it. The master side is the sequencer.
interface instr_sequencer_if;
    logic [7:0] Rom_Data;
    logic [3:0] Pc;
    logic       Carry_N;
    logic       Step;
    logic [3:0] Load_N;
    logic       Sel_A;
    logic       Sel_B;
    logic [3:0] Im;
    logic       Exec_En;
    logic       Halted;
    logic       Illegal;

    modport master (
        input  Rom_Data, Pc, Carry_N, Step,
        output Load_N, Sel_A, Sel_B, Im, Exec_En, Halted, Illegal
    );

    modport slave (
        output Rom_Data, Pc, Carry_N, Step,
        input  Load_N, Sel_A, Sel_B, Im, Exec_En, Halted, Illegal
    );
endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer for a 4-bit accumulator CPU.
// Runs FETCH -> DECODE -> EXECUTE, three clocks per instruction, and drives
// the register load strobes, data-selector bits and the immediate field.
// A JMP to its own address parks the sequencer in HALT until reset
// (HALT_DETECT = 1).
// Optional feature: define SEQ_SINGLE_STEP_EN to run one instruction per
// Step pulse, with the sequencer returning to IDLE after each EXECUTE.
module instr_sequencer #(
    parameter int HALT_DETECT = 1
) (
    input  logic                CLK,
    input  logic                CLR,
    instr_sequencer_if.master   bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_HALT    = 3'd4
    } state_t;

    state_t      state_r;
    logic [7:0]  ir_r;
    logic        halt_pend_r;
    logic [3:0]  load_n_r;
    logic        sel_a_r;
    logic        sel_b_r;
    logic        exec_en_r;
    logic        halted_r;
    logic        illegal_r;

    logic [6:0]  dec_s;
    logic        halt_hit_s;

    // Opcode decode, packed as {sel_b, sel_a, load_n[3:0], illegal}.
    // Load strobe order is [0] A, [1] B, [2] OUT, [3] PC, active low.
    function automatic logic [6:0] decode_f(input logic [3:0] op, input logic carry_n);
        logic [6:0] r;
        case (op)
            4'b0000: r = {2'b00, 4'b1110, 1'b0};   // ADD A,Im
            4'b0001: r = {2'b01, 4'b1110, 1'b0};   // MOV A,B
            4'b0010: r = {2'b10, 4'b1110, 1'b0};   // IN  A
            4'b0011: r = {2'b11, 4'b1110, 1'b0};   // MOV A,Im
            4'b0100: r = {2'b00, 4'b1101, 1'b0};   // MOV B,A
            4'b0101: r = {2'b01, 4'b1101, 1'b0};   // ADD B,Im
            4'b0110: r = {2'b10, 4'b1101, 1'b0};   // IN  B
            4'b0111: r = {2'b11, 4'b1101, 1'b0};   // MOV B,Im
            4'b1001: r = {2'b01, 4'b1011, 1'b0};   // OUT B
            4'b1011: r = {2'b11, 4'b1011, 1'b0};   // OUT Im
            4'b1111: r = {2'b11, 4'b0111, 1'b0};   // JMP
            // JNC: a taken-not jump is a plain NOP, not an illegal opcode
            4'b1110: r = carry_n ? {2'b11, 4'b0111, 1'b0} : {2'b11, 4'b1111, 1'b0};
            // 1000, 1010, 1100, 1101: undefined, executed as flagged NOPs
            default: r = {2'b11, 4'b1111, 1'b1};
        endcase
        return r;
    endfunction

    // Decode the latched instruction against the live carry flag and PC
    always_comb begin
        dec_s = decode_f(ir_r[7:4], bus.Carry_N);
        if ((HALT_DETECT != 0) && (ir_r[7:4] == 4'b1111) && (ir_r[3:0] == bus.Pc)) begin
            halt_hit_s = 1'b1;
        end else begin
            halt_hit_s = 1'b0;
        end
    end

    // Sequencer FSM with all control outputs registered
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_r     <= ST_IDLE;
            ir_r        <= 8'h00;
            halt_pend_r <= 1'b0;
            load_n_r    <= 4'b1111;
            sel_a_r     <= 1'b0;
            sel_b_r     <= 1'b0;
            exec_en_r   <= 1'b0;
            halted_r    <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    load_n_r  <= 4'b1111;
                    exec_en_r <= 1'b0;
                    illegal_r <= 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
                    if (bus.Step) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_IDLE;
                    end
`else
                    state_r <= ST_FETCH;
`endif
                end
                ST_FETCH: begin
                    ir_r    <= bus.Rom_Data;
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    // Carry and PC are sampled here only; later changes do
                    // not alter the instruction in flight.
                    sel_b_r     <= dec_s[6];
                    sel_a_r     <= dec_s[5];
                    load_n_r    <= dec_s[4:1];
                    illegal_r   <= dec_s[0];
                    exec_en_r   <= 1'b1;
                    halt_pend_r <= halt_hit_s;
                    state_r     <= ST_EXECUTE;
                end
                ST_EXECUTE: begin
                    load_n_r    <= 4'b1111;
                    exec_en_r   <= 1'b0;
                    illegal_r   <= 1'b0;
                    halt_pend_r <= 1'b0;
                    if (halt_pend_r) begin
                        halted_r <= 1'b1;
                        state_r  <= ST_HALT;
                    end else begin
`ifdef SEQ_SINGLE_STEP_EN
                        state_r <= ST_IDLE;
`else
                        state_r <= ST_FETCH;
`endif
                    end
                end
                ST_HALT: begin
                    load_n_r  <= 4'b1111;
                    exec_en_r <= 1'b0;
                    illegal_r <= 1'b0;
                    halted_r  <= 1'b1;
                    state_r   <= ST_HALT;
                end
                default: begin
                    load_n_r    <= 4'b1111;
                    exec_en_r   <= 1'b0;
                    illegal_r   <= 1'b0;
                    halted_r    <= 1'b0;
                    halt_pend_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

`ifndef SEQ_SINGLE_STEP_EN
    // Step has no function when the sequencer free-runs
    logic unused_step_s;
    assign unused_step_s = bus.Step;
`endif

    assign bus.Load_N  = load_n_r;
    assign bus.Sel_A   = sel_a_r;
    assign bus.Sel_B   = sel_b_r;
    assign bus.Im      = ir_r[3:0];
    assign bus.Exec_En = exec_en_r;
    assign bus.Halted  = halted_r;
    assign bus.Illegal = illegal_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios with literal
// expectations, then randomized instructions, flags and resets, all checked
// every cycle against a behavioural model of the instruction timeline.
module tb_instr_sequencer;

    localparam int HALT_DETECT = 1;
`ifdef SEQ_SINGLE_STEP_EN
    localparam bit STEP_MODE = 1'b1;
`else
    localparam bit STEP_MODE = 1'b0;
`endif

    logic CLK;
    logic CLR;
    instr_sequencer_if bus();

    instr_sequencer #(.HALT_DETECT(HALT_DETECT)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- opcode table ----------------
    logic [1:0] sel_tab [16];
    int         tgt_tab [16];   // 0=A 1=B 2=OUT 3=PC, -1 = no load
    bit         ill_tab [16];

    initial begin
        for (int i = 0; i < 16; i++) begin
            sel_tab[i] = 2'b11;
            tgt_tab[i] = -1;
            ill_tab[i] = 1'b0;
        end
        sel_tab[0]  = 2'b00; tgt_tab[0]  = 0;
        sel_tab[1]  = 2'b01; tgt_tab[1]  = 0;
        sel_tab[2]  = 2'b10; tgt_tab[2]  = 0;
        sel_tab[3]  = 2'b11; tgt_tab[3]  = 0;
        sel_tab[4]  = 2'b00; tgt_tab[4]  = 1;
        sel_tab[5]  = 2'b01; tgt_tab[5]  = 1;
        sel_tab[6]  = 2'b10; tgt_tab[6]  = 1;
        sel_tab[7]  = 2'b11; tgt_tab[7]  = 1;
        sel_tab[9]  = 2'b01; tgt_tab[9]  = 2;
        sel_tab[11] = 2'b11; tgt_tab[11] = 2;
        sel_tab[15] = 2'b11; tgt_tab[15] = 3;
        sel_tab[14] = 2'b11; tgt_tab[14] = 3;   // conditional on carry
        ill_tab[8]  = 1'b1;
        ill_tab[10] = 1'b1;
        ill_tab[12] = 1'b1;
        ill_tab[13] = 1'b1;
    end

    // ---------------- behavioural model ----------------
    // m_k counts the clocks spent in the current instruction: 0 fetch,
    // 1 decode, 2 execute.
    bit         m_idle;
    bit         m_halted;
    int         m_k;
    logic [7:0] m_ir;
    logic [3:0] m_ldn;
    logic [1:0] m_sel;
    bit         m_ill;
    bit         m_halt_after;
    logic [3:0] m_op;
    int         m_tgt;

    always @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            m_idle       = 1'b1;
            m_halted     = 1'b0;
            m_k          = 0;
            m_ir         = 8'h00;
            m_ldn        = 4'b1111;
            m_sel        = 2'b00;
            m_ill        = 1'b0;
            m_halt_after = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (m_idle) begin
            if (!STEP_MODE || bus.Step) begin
                m_idle = 1'b0;
                m_k    = 0;
            end
        end else if (m_k == 0) begin
            m_ir = bus.Rom_Data;
            m_k  = 1;
        end else if (m_k == 1) begin
            m_op  = m_ir[7:4];
            m_tgt = tgt_tab[m_op];
            if (m_op == 4'd14 && !bus.Carry_N) m_tgt = -1;
            m_ldn = (m_tgt < 0) ? 4'b1111 : ~(4'b0001 << m_tgt);
            m_sel = sel_tab[m_op];
            m_ill = ill_tab[m_op];
            m_halt_after = (HALT_DETECT != 0) && (m_op == 4'd15) && (m_ir[3:0] == bus.Pc);
            m_k = 2;
        end else begin
            if (m_halt_after)   m_halted = 1'b1;
            else if (STEP_MODE) m_idle   = 1'b1;
            else                m_k      = 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    bit         e_exec;
    logic [3:0] e_ldn;

    always @(negedge CLK) begin
        if (cmp_en) begin
            e_exec = CLR && !m_idle && !m_halted && (m_k == 2);
            e_ldn  = e_exec ? m_ldn : 4'b1111;
            chk("cmp_load_n",  8'(bus.Load_N),  8'(e_ldn));
            chk("cmp_sel",     8'({bus.Sel_B, bus.Sel_A}), 8'(m_sel));
            chk("cmp_im",      8'(bus.Im),      8'(m_ir[3:0]));
            chk("cmp_exec_en", 8'(bus.Exec_En), 8'(e_exec));
            chk("cmp_halted",  8'(bus.Halted),  8'(m_halted));
            chk("cmp_illegal", 8'(bus.Illegal), 8'(e_exec && m_ill));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    // Hold reset for two clocks; returns just after releasing it
    task automatic reset_dut();
        tick();
        CLR = 1'b0;
        tick();
        tick();
        CLR = 1'b1;
    endtask

    int hcnt;
    int hlim;

    initial begin
        CLR          = 1'b0;
        bus.Rom_Data = 8'h00;
        bus.Pc       = 4'h0;
        bus.Carry_N  = 1'b1;
        bus.Step     = 1'b0;
        tick();
        tick();
        cmp_en = 1'b1;
        // reset state
        chk("rst_load_n",  8'(bus.Load_N),  8'h0f);
        chk("rst_sel",     8'({bus.Sel_B, bus.Sel_A}), 8'h00);
        chk("rst_im",      8'(bus.Im),      8'h00);
        chk("rst_exec_en", 8'(bus.Exec_En), 8'h00);
        chk("rst_halted",  8'(bus.Halted),  8'h00);
        chk("rst_illegal", 8'(bus.Illegal), 8'h00);

`ifndef SEQ_SINGLE_STEP_EN
        // MOV A,5
        bus.Rom_Data = 8'h35;
        reset_dut();
        tick();
        chk("mov_fetch_load_n", 8'(bus.Load_N), 8'h0f);
        tick();
        chk("mov_decode_load_n", 8'(bus.Load_N), 8'h0f);
        chk("mov_decode_im", 8'(bus.Im), 8'h05);
        tick();
        chk("mov_exec_load_n", 8'(bus.Load_N), 8'h0e);
        chk("mov_exec_sel", 8'({bus.Sel_B, bus.Sel_A}), 8'h03);
        chk("mov_exec_im", 8'(bus.Im), 8'h05);
        chk("mov_exec_en", 8'(bus.Exec_En), 8'h01);

        // JNC 7 with no carry, to its own address
        bus.Rom_Data = 8'hE7;
        bus.Pc       = 4'h7;
        bus.Carry_N  = 1'b1;
        tick();
        tick();
        tick();
        bus.Carry_N = 1'b0;
        #1;
        chk("jnc_taken_load_n", 8'(bus.Load_N), 8'h07);
        chk("jnc_taken_illegal", 8'(bus.Illegal), 8'h00);
        tick();
        chk("jnc_self_no_halt", 8'(bus.Halted), 8'h00);
        tick();
        tick();
        chk("jnc_nottaken_load_n", 8'(bus.Load_N), 8'h0f);
        chk("jnc_nottaken_illegal", 8'(bus.Illegal), 8'h00);
        chk("jnc_nottaken_exec", 8'(bus.Exec_En), 8'h01);

        // undefined opcode
        bus.Rom_Data = 8'h80;
        tick();
        tick();
        tick();
        chk("nop80_illegal", 8'(bus.Illegal), 8'h01);
        chk("nop80_load_n", 8'(bus.Load_N), 8'h0f);
        chk("nop80_exec", 8'(bus.Exec_En), 8'h01);
        tick();
        chk("nop80_illegal_end", 8'(bus.Illegal), 8'h00);

        // self-jump halt
        bus.Rom_Data = 8'hF3;
        bus.Pc       = 4'h3;
        tick();
        tick();
        chk("jmp_exec_load_n", 8'(bus.Load_N), 8'h07);
        chk("jmp_exec_en", 8'(bus.Exec_En), 8'h01);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("halt_halted", 8'(bus.Halted), 8'h01);
            chk("halt_load_n", 8'(bus.Load_N), 8'h0f);
            chk("halt_exec", 8'(bus.Exec_En), 8'h00);
        end
        tick();
        CLR = 1'b0;
        #1;
        chk("halt_clr_halted", 8'(bus.Halted), 8'h00);
        chk("halt_clr_im", 8'(bus.Im), 8'h00);

        // reset dropped during decode of MOV B,A
        bus.Rom_Data = 8'h4A;
        bus.Pc       = 4'h0;
        tick();
        CLR = 1'b1;
        tick();
        tick();
        CLR = 1'b0;
        #1;
        chk("abort_load_n", 8'(bus.Load_N), 8'h0f);
        chk("abort_exec", 8'(bus.Exec_En), 8'h00);
        chk("abort_im", 8'(bus.Im), 8'h00);
        chk("abort_sel", 8'({bus.Sel_B, bus.Sel_A}), 8'h00);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("abort_hold_load_n", 8'(bus.Load_N), 8'h0f);
        end
        CLR = 1'b1;
        tick();
        tick();
        tick();
        chk("restart_load_n", 8'(bus.Load_N), 8'h0d);
        chk("restart_sel", 8'({bus.Sel_B, bus.Sel_A}), 8'h00);
`else
        // no Step: stays idle
        bus.Rom_Data = 8'h90;
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("step_idle_exec", 8'(bus.Exec_En), 8'h00);
        end
        bus.Step = 1'b1;
        tick();
        bus.Step = 1'b0;
        tick();
        tick();
        chk("step_exec_load_n", 8'(bus.Load_N), 8'h0b);
        chk("step_exec_sel", 8'({bus.Sel_B, bus.Sel_A}), 8'h01);
        chk("step_exec_en", 8'(bus.Exec_En), 8'h01);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("step_after_exec", 8'(bus.Exec_En), 8'h00);
            chk("step_after_load_n", 8'(bus.Load_N), 8'h0f);
        end
`endif

        // randomized run
        CLR  = 1'b1;
        hcnt = 0;
        hlim = 4;
        for (int c = 0; c < 3000; c++) begin
            tick();
            if (!CLR) begin
                CLR = 1'b1;
            end else if (m_halted) begin
                hcnt++;
                if (hcnt >= hlim) begin
                    CLR  = 1'b0;
                    hcnt = 0;
                    hlim = $urandom_range(2, 10);
                end
            end else if ($urandom_range(0, 99) == 0) begin
                CLR = 1'b0;
            end
            bus.Rom_Data = 8'($urandom_range(0, 255));
            bus.Pc       = 4'($urandom_range(0, 15));
            bus.Carry_N  = 1'($urandom_range(0, 1));
            bus.Step     = ($urandom_range(0, 3) == 0);
        end
        tick();
        cmp_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 Parameter: HALT_DETECT, default 1, enables detection of the self-jump halt (JMP to own address).
REQ-002 CLK  input  1  system clock; all state updates on posedge CLK.
REQ-003 CLR  input  1  reset; asynchronous, active-low (one clock; reset is asynchronous and active-low).
REQ-004 Rom_Data  input  8  instruction word at the current PC; [7:4] opcode, [3:0] immediate.
REQ-005 Pc  input  4  current program-counter value.
REQ-006 Carry_N  input  1  flag-register output, negative logic: 1 = no carry.
REQ-007 Step  input  1  single-step request pulse; used only when SEQ_SINGLE_STEP_EN is defined.
REQ-008 Load_N  output  4  active-low load strobes: [0] A, [1] B, [2] OUT, [3] PC.
REQ-009 Sel_A  output  1  data-selector bit A.
REQ-010 Sel_B  output  1  data-selector bit B.
REQ-011 Im  output  4  latched immediate field.
REQ-012 Exec_En  output  1  one-cycle register-update enable for the A, B, OUT and PC register EN inputs.
REQ-013 Halted  output  1  high while in HALT.
REQ-014 Illegal  output  1  one-cycle pulse on an undefined opcode.

Function
REQ-015 FSM states: IDLE, FETCH, DECODE, EXECUTE, HALT.
REQ-016 IDLE->FETCH on the next clock (free-run); FETCH->DECODE->EXECUTE->FETCH, one clock each; each instruction takes 3 cycles.
REQ-017 FETCH: latch Rom_Data into an 8-bit instruction register; Im is driven from IR[3:0].
REQ-018 DECODE: sample Carry_N into a jump-condition register; compute Sel_A, Sel_B and Load_N into registered outputs.
REQ-019 Load_N = 4'b1111 and Exec_En = 0 in every state except EXECUTE; in EXECUTE Exec_En = 1 and Load_N carries the decoded value.
REQ-020 Decode (op: Sel_B Sel_A, asserted load): 0000 ADD A,Im: 00, A; 0001 MOV A,B: 01, A; 0010 IN A: 10, A; 0011 MOV A,Im: 11, A; 0100 MOV B,A: 00, B; 0101 ADD B,Im: 01, B; 0110 IN B: 10, B; 0111 MOV B,Im: 11, B; 1001 OUT B: 01, OUT; 1011 OUT Im: 11, OUT; 1111 JMP: 11, PC; 1110 JNC: 11, PC only if sampled Carry_N = 1.
REQ-021 Opcodes 1000, 1010, 1100 and 1101 are NOPs: Load_N = 4'b1111, Sel = 11, Exec_En still pulses in EXECUTE, Illegal pulses in EXECUTE.
REQ-022 JNC with Carry_N = 0 executes as a NOP without an Illegal pulse.
REQ-023 With HALT_DETECT = 1, JMP with IR[3:0] == Pc at DECODE: EXECUTE performs the load, then the FSM enters HALT instead of FETCH.
REQ-024 HALT: Load_N = 4'b1111, Exec_En = 0, Halted = 1; HALT is left only by reset.
REQ-025 JNC to its own address does not halt.
REQ-026 Carry_N changes after DECODE do not affect the current instruction.

Reset
REQ-027 CLR low: FSM = IDLE, IR = 8'h00, Load_N = 4'b1111, Sel_A = Sel_B = 0, Im = 0, Exec_En = 0, Halted = 0, Illegal = 0.
REQ-028 CLR asserted mid-instruction: aborts immediately with no partial load strobe; restart from IDLE after CLR rises.

Configuration
REQ-029 SEQ_SINGLE_STEP_EN defined: IDLE->FETCH only on a cycle with Step = 1, and EXECUTE returns to IDLE; exactly one instruction runs per Step pulse, and Step seen outside IDLE is ignored.
REQ-030 SEQ_SINGLE_STEP_EN undefined: Step is ignored and the sequencer free-runs per REQ-016.

Verification
REQ-031 Reset, Rom_Data = 8'h35 (MOV A,5): Load_N = 1111 for cycles 1-2 after FETCH; EXECUTE gives Load_N = 1110, Sel = 11, Im = 5, Exec_En = 1.
REQ-032 8'hE7 (JNC 7): with Carry_N = 1 at DECODE -> Load_N = 0111 in EXECUTE; with Carry_N = 0 -> 1111 and no Illegal.
REQ-033 Pc = 4'h3, Rom_Data = 8'hF3 -> PC load in EXECUTE, then Halted = 1 held 20 cycles with Load_N = 1111; CLR pulse -> IDLE.
REQ-034 8'h80 -> Illegal pulses for one cycle in EXECUTE, and Load_N stays 1111.
REQ-035 CLR dropped during DECODE of 8'h4x -> Load_N never goes to 1101, and outputs take reset values.
REQ-036 SEQ_SINGLE_STEP_EN defined: no Step -> stays in IDLE; one Step pulse of 8'h90 -> exactly one Exec_En pulse with Load_N = 1011, then IDLE.
